// File: rtl/ct_deserializer.sv
// ct_deserializer: assembles one ciphertext (A[0..N-1] then B[0..N-1]) from a coefficient stream, reducing each word by q at most once.
// Latency: out_valid rises the cycle after the 2N-th accept (2N cycles from the first accept with no input gaps).
// Backpressure: in_ready drops while a complete ciphertext is held; out_ct/out_err stay frozen until out_ready.
module ct_deserializer #(
  parameter int             N  = 4,
  parameter int             W  = 8,
  parameter logic [W-1:0]   QP = W'(17)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_coef,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N*W-1:0] out_ct,
  output logic             out_err
);

  // out_ct layout: A[i] at bits [i*W +: W], B[i] at bits [(N+i)*W +: W],
  // so the k-th word of the stream lands in slot k.
  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {FILL_A, FILL_B, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          err_q;
  logic [W-1:0]  a_q [N];
  logic [W-1:0]  b_q [N];

  logic          accept;
  logic          coef_hi;
  logic [W-1:0]  coef_red;

  // in_ready is a registered output, so accept never depends combinationally on itself.
  assign accept   = in_valid & in_ready;
  assign coef_hi  = (in_coef >= QP);
  assign coef_red = coef_hi ? (in_coef - QP) : in_coef;
  assign out_err  = err_q;

  // Fill/hold sequencing with registered handshake outputs and the sticky range-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL_A;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        FILL_A, FILL_B: begin
          if (accept) begin
            if (coef_hi) begin
              err_q <= 1'b1;
            end
            if (idx == IDX_LAST) begin
              idx <= '0;
              if (state == FILL_A) begin
                state <= FILL_B;
              end else begin
                state     <= HOLD;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FILL_A;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        default: begin
          state     <= FILL_A;
          idx       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          err_q     <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient storage: the reduced word goes to A or B at the current index; untouched slots keep old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (accept) begin
      if (state == FILL_A) begin
        a_q[idx] <= coef_red;
      end else begin
        b_q[idx] <= coef_red;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign out_ct[i*W +: W]     = a_q[i];
    assign out_ct[(N+i)*W +: W] = b_q[i];
  end

endmodule

// File: tb/tb_ct_deserializer.sv
// Bench for ct_deserializer with N=4, W=8, QP=17.
// A stream-level model (accepted words -> pending ciphertext) is compared every cycle;
// directed scenarios add literal expectations for contents, latency and back-pressure.
module tb_ct_deserializer;

  localparam int           N  = 4;
  localparam int           W  = 8;
  localparam logic [W-1:0] QP = 8'd17;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_coef   = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*N*W-1:0] out_ct;
  logic             out_err;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int hs_cnt = 0;
  int rises  = 0;
  int first_cyc = 0;

  logic rand_rdy   = 1'b0;
  logic rdy_val    = 1'b0;
  logic prev_valid = 1'b0;

  // Model state: words accepted so far for the current ciphertext, and the completed one awaiting handshake.
  logic [W-1:0]     words[$];
  logic             holding = 1'b0;
  logic [2*N*W-1:0] exp_ct  = '0;
  logic             exp_err = 1'b0;

  logic [W-1:0] stim [8];

  ct_deserializer #(.N(N), .W(W), .QP(QP)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_coef  (in_coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ct   (out_ct),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sole driver of out_ready: either a fixed level or a random coin per cycle.
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic logic [W-1:0] red(input logic [W-1:0] v);
    return (v >= QP) ? v - QP : v;
  endfunction

  // Per-cycle comparison against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      words.delete();
      holding = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_err", out_err, 1'b0);
    end else begin
      chk("out_valid", out_valid, holding);
      chk("in_ready", in_ready, !holding);
      if (holding) begin
        chk("out_ct", out_ct, exp_ct);
        chk("out_err", out_err, exp_err);
      end
      if (holding && out_ready) begin
        holding = 1'b0;
        hs_cnt++;
      end else if (!holding && in_valid) begin
        words.push_back(in_coef);
        if (words.size() == 2*N) begin
          exp_err = 1'b0;
          for (int k = 0; k < 2*N; k++) begin
            exp_ct[k*W +: W] = red(words[k]);
            if (words[k] >= QP) exp_err = 1'b1;
          end
          holding = 1'b1;
          words.delete();
        end
      end
    end
    if (out_valid && !prev_valid) rises++;
    prev_valid = out_valid;
  end

  // Present one word and keep it until an edge where in_ready was high.
  task automatic send_word(input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_coef  = w;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      ok = in_ready && !rst;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("send_accept_timeout", ok, 1'b1);
  endtask

  task automatic send_ct(input bit gaps, input bit keep);
    for (int k = 0; k < 2*N; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_word(stim[k]);
      if (k == 0) first_cyc = cyc;
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic handshake();
    rdy_val = 1'b1;
    @(posedge clk);
    #1;
    rdy_val = 1'b0;
    chk("hs_out_valid_low", out_valid, 1'b0);
    chk("hs_in_ready_high", in_ready, 1'b1);
  endtask

  initial begin
    int c1, c2, base_hs, base_r;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_ct", out_ct, 64'd0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_err", out_err, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic fill with in_valid held high.
    stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_ct(1'b0, 1'b0);
    chk("t1_latency", cyc - first_cyc + 1, 8);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_ct", out_ct, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    chk("t1_err", out_err, 1'b0);
    handshake();

    // Range reduction and error flag, then a clean ciphertext clears it.
    stim = '{8'd16, 8'd17, 8'd20, 8'd0, 8'd33, 8'd1, 8'd2, 8'd3};
    send_ct(1'b0, 1'b0);
    chk("t2_ct", out_ct, {8'd3, 8'd2, 8'd1, 8'd16, 8'd0, 8'd3, 8'd0, 8'd16});
    chk("t2_err", out_err, 1'b1);
    handshake();
    stim = '{8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9};
    send_ct(1'b0, 1'b0);
    chk("t2_clean_ct", out_ct, {8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16});
    chk("t2_clean_err", out_err, 1'b0);
    handshake();

    // Back-pressure with a pending upstream word.
    stim = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28};
    send_ct(1'b0, 1'b1);
    in_coef = 8'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t3_hold_in_ready", in_ready, 1'b0);
      chk("t3_hold_ct", out_ct, {8'd11, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4});
      chk("t3_hold_err", out_err, 1'b1);
    end
    handshake();
    stim = '{8'd99, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    send_ct(1'b0, 1'b0);
    chk("t3_next_ct", out_ct, {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd82});
    chk("t3_next_err", out_err, 1'b1);
    handshake();

    // Back-to-back ciphertexts with out_ready held high.
    rdy_val = 1'b1;
    stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_ct(1'b0, 1'b1);
    c1 = cyc;
    chk("t4_first_valid", out_valid, 1'b1);
    stim = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    send_ct(1'b0, 1'b0);
    c2 = cyc;
    rdy_val = 1'b0;
    chk("t4_second_valid", out_valid, 1'b1);
    chk("t4_spacing", c2 - c1, 9);
    chk("t4_second_ct", out_ct, {8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9});
    handshake();

    // Random input gaps and random downstream readiness over three ciphertexts.
    base_hs  = hs_cnt;
    base_r   = rises;
    rand_rdy = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 2*N; k++) stim[k] = 8'($urandom_range(0, 40));
      send_ct(1'b1, 1'b0);
    end
    for (int t = 0; t < 300; t++) begin
      if (hs_cnt == base_hs + 3) break;
      @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    rdy_val  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_handshakes", hs_cnt - base_hs, 3);
    chk("t5_valid_windows", rises - base_r, 3);

    // Reset mid-fill discards partial data; words offered during reset are ignored.
    for (int k = 0; k < 5; k++) send_word(8'(30 + k));
    in_valid = 1'b1;
    in_coef  = 8'd77;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_ct", out_ct, 64'd0);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_in_ready", in_ready, 1'b1);
    chk("t6_rst_err", out_err, 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    stim = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    send_ct(1'b0, 1'b0);
    chk("t6_ct", out_ct, {8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9});
    chk("t6_err", out_err, 1'b0);
    handshake();

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
